// File: rtl/iter_alu.sv
// ----------------------------------------------------------------------------
// iter_alu -- integer ALU with single-cycle logic/arithmetic ops and an
// iterative (one bit per cycle) unsigned multiplier and restoring divider.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   in_valid   request valid          in_ready  request can be accepted (IDLE)
//   aluop      operation code (0..13 legal, 14..15 flagged illegal)
//   portA/B    WIDTH-bit operands, captured at the accept edge
//   out_valid  result valid (DONE)    out_ready consumer takes the result
//   result     WIDTH-bit result
//   zero, neg, ovf, dz, ill           result flags, registered with result
//
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SLT,
//          9 SLTU, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU.
// ----------------------------------------------------------------------------
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             dz,
    output logic             ill
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_reg;    // MUL: running partial product high half; DIV: remainder
    logic [WIDTH-1:0] lo_reg;    // MUL: multiplier / product low half; DIV: dividend / quotient
    logic [CNTW-1:0]  cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic             ovf_reg;
    logic             dz_reg;
    logic             ill_reg;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;
    assign ovf       = ovf_reg;
    assign dz        = dz_reg;
    assign ill       = ill_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs so the result can
    // be registered at the very edge that accepts the request.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [CNTW-2:0]  shamt;
    logic [WIDTH-1:0] fast_res;
    logic             fast_ovf;
    logic             fast_ill;
    logic             req_iter;
    logic             req_div;

    assign add_sum  = portA + portB;
    assign sub_diff = portA - portB;
    assign shamt    = portB[CNTW-2:0];
    assign req_iter = (aluop >= OP_MUL) && (aluop <= OP_REMU);
    assign req_div  = (aluop == OP_DIVU) || (aluop == OP_REMU);

    always_comb begin
        fast_res = '0;
        fast_ovf = 1'b0;
        fast_ill = 1'b0;
        case (aluop)
            OP_ADD: begin
                fast_res = add_sum;
                fast_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != portA[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res = sub_diff;
                fast_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) &&
                           (sub_diff[WIDTH-1] != portA[WIDTH-1]);
            end
            OP_AND:  fast_res = portA & portB;
            OP_OR:   fast_res = portA | portB;
            OP_XOR:  fast_res = portA ^ portB;
            OP_NOR:  fast_res = ~(portA | portB);
            OP_SLL:  fast_res = portA << shamt;
            OP_SRL:  fast_res = portA >> shamt;
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
            OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: fast_res = '0;  // handled iteratively
            default: fast_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: one shift-add or restoring-divide step per cycle.
    // ------------------------------------------------------------------
    logic             op_div;
    logic             b_zero;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign op_div  = (op_reg == OP_DIVU) || (op_reg == OP_REMU);
    assign b_zero  = (b_reg == '0);

    // Add the multiplicand when the current multiplier LSB is set; the
    // {hi,lo} pair then shifts right by one, carry entering the top.
    assign mul_sum = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? a_reg : {WIDTH{1'b0}})};

    // Remainder shifted left with the next dividend bit. The remainder stays
    // below the divisor, so a successful subtraction always fits in WIDTH
    // bits. A zero divisor always "subtracts", which naturally yields an
    // all-ones quotient and a remainder equal to the dividend.
    assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    assign div_diff  = div_shift[WIDTH-1:0] - b_reg;

    always_comb begin
        if (op_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // Result selection from the values produced by the final step.
    logic [WIDTH-1:0] fin_res;
    logic             fin_ovf;
    logic             fin_dz;

    always_comb begin
        fin_res = step_lo;
        fin_ovf = 1'b0;
        fin_dz  = 1'b0;
        case (op_reg)
            OP_MUL: begin
                fin_res = step_lo;
                fin_ovf = |step_hi;
            end
            OP_MULHU: fin_res = step_hi;
            OP_DIVU: begin
                fin_res = step_lo;
                fin_dz  = b_zero;
            end
            OP_REMU: begin
                fin_res = step_hi;
                fin_dz  = b_zero;
            end
            default: fin_res = step_lo;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            dz_reg     <= 1'b0;
            ill_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg  <= aluop;
                        a_reg   <= portA;
                        b_reg   <= portB;
                        cnt_reg <= '0;
                        if (req_iter) begin
                            hi_reg    <= '0;
                            lo_reg    <= req_div ? portA : portB;
                            state_reg <= BUSY;
                        end else begin
                            result_reg <= fast_res;
                            zero_reg   <= (fast_res == '0);
                            neg_reg    <= fast_res[WIDTH-1];
                            ovf_reg    <= fast_ovf;
                            dz_reg     <= 1'b0;
                            ill_reg    <= fast_ill;
                            state_reg  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    hi_reg  <= step_hi;
                    lo_reg  <= step_lo;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        result_reg <= fin_res;
                        zero_reg   <= (fin_res == '0);
                        neg_reg    <= fin_res[WIDTH-1];
                        ovf_reg    <= fin_ovf;
                        dz_reg     <= fin_dz;
                        ill_reg    <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// ----------------------------------------------------------------------------
// tb_iter_alu -- scoreboard bench for iter_alu (WIDTH=32). The driver pushes
// hand-computed expectations at each accepted request; an independent monitor
// compares result, flags and latency whenever the DUT presents out_valid.
// ----------------------------------------------------------------------------
module tb_iter_alu;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   aluop;
    logic [W-1:0] portA;
    logic [W-1:0] portB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         dz;
    logic         ill;

    iter_alu #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .portA     (portA),
        .portB     (portB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
        .dz        (dz),
        .ill       (ill)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string      name;
        logic [31:0] res;
        logic [4:0]  fl;     // {zero, neg, ovf, dz, ill}
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void fail_now(string name, string why);
        n_total++;
        $display("FAIL %s: %s", name, why);
    endfunction

    // Issue one request; operands are scrambled right after the accept edge.
    task automatic issue(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] res, logic [4:0] fl, int lat, bit push);
        int n = 0;
        exp_t e;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            fail_now({name, "_accept"}, "in_ready never asserted within 200 cycles");
            return;
        end
        aluop    = op;
        portA    = a;
        portB    = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        if (push) begin
            e.name = name;
            e.res  = res;
            e.fl   = fl;
            e.lat  = lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        aluop    = 4'($urandom_range(0, 15));
        portA    = $urandom();
        portB    = $urandom();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (sb.size() != 0) fail_now("drain", "expected results never appeared");
        sb.delete();
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // Monitor: latency on the rising out_valid, contents every valid cycle,
    // pop on handshake.
    initial begin
        bit prev = 1'b0;
        exp_t h;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        if (!prev) fail_now("unexpected_output", $sformatf("out_valid with result %h and nothing outstanding", result));
                    end else begin
                        h = sb[0];
                        if (!prev) chk({h.name, "_latency"}, 64'(cyc - h.acc + 1), 64'(h.lat));
                        chk({h.name, "_result"}, 64'(result), 64'(h.res));
                        chk({h.name, "_flags"}, 64'({zero, neg, ovf, dz, ill}), 64'(h.fl));
                        if (out_ready) begin
                            $display("txn %s result=%h flags(z,n,o,d,i)=%b", h.name, result, {zero, neg, ovf, dz, ill});
                            void'(sb.pop_front());
                        end
                    end
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        aluop     = 4'd0;
        portA     = '0;
        portB     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({zero, neg, ovf, dz, ill}), 64'd0);

        //    name        op     A             B             result        z n o d i   lat
        issue("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01100, 1,  1);
        issue("mul_hi",   4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 5'b10100, 33, 1);
        issue("mulhu",    4'd11, 32'h00010000, 32'h00010000, 32'h00000001, 5'b00000, 33, 1);
        issue("divu",     4'd12, 32'd100,      32'd7,        32'd14,       5'b00000, 33, 1);
        issue("remu",     4'd13, 32'd100,      32'd7,        32'd2,        5'b00000, 33, 1);
        issue("divu_dz",  4'd12, 32'd5,        32'd0,        32'hFFFFFFFF, 5'b01010, 33, 1);
        issue("remu_dz",  4'd13, 32'd5,        32'd0,        32'd5,        5'b00010, 33, 1);
        issue("ill15",    4'd15, 32'h12345678, 32'h9ABCDEF0, 32'd0,        5'b10001, 1,  1);
        issue("slt_neg",  4'd8,  32'hFFFFFFFF, 32'd1,        32'd1,        5'b00000, 1,  1);
        issue("sll_31",   4'd6,  32'd1,        32'd31,       32'h80000000, 5'b01000, 1,  1);
        issue("sub_ovf",  4'd1,  32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b00100, 1,  1);
        issue("and",      4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000, 1,  1);
        issue("or",       4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'b01000, 1,  1);
        issue("xor",      4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'b00000, 1,  1);
        issue("nor",      4'd5,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b01000, 1,  1);
        issue("srl_mask", 4'd7,  32'h80000000, 32'h00000024, 32'h08000000, 5'b00000, 1,  1);
        issue("mul_ff",   4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00100, 33, 1);
        issue("mulhu_ff", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b01000, 33, 1);
        issue("ill14",    4'd14, 32'd1,        32'd1,        32'd0,        5'b10001, 1,  1);
        issue("add_mix",  4'd0,  32'd5,        32'hFFFFFFFD, 32'd2,        5'b00000, 1,  1);
        issue("divu_big", 4'd12, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 5'b00000, 33, 1);
        issue("remu_big", 4'd13, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 5'b00000, 33, 1);
        issue("slt_pos",  4'd8,  32'd1,        32'hFFFFFFFF, 32'd0,        5'b10000, 1,  1);
        drain();

        // Result held while the consumer stalls; a new request is ignored.
        out_ready = 1'b0;
        issue("sub_hold", 4'd1, 32'd3, 32'd3, 32'd0, 5'b10000, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(result), 64'd0);
            chk("hold_zero", 64'(zero), 64'd1);
            if (i == 1) begin
                in_valid = 1'b1;
                aluop    = 4'd0;
                portA    = 32'd7;
                portB    = 32'd9;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge CLK);
        #1 out_ready = 1'b1;
        drain();
        chk("after_hold_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a divide discards it; in_valid during reset
        // is not taken.
        issue("divu_abort", 4'd12, 32'd1000, 32'd3, 32'd0, 5'b00000, 33, 0);
        repeat (10) @(posedge CLK);
        #1;
        RST      = 1'b1;
        in_valid = 1'b1;
        aluop    = 4'd0;
        portA    = 32'd1;
        portB    = 32'd1;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        repeat (40) @(posedge CLK);
        #1;
        chk("abort_still_idle", 64'(in_ready), 64'd1);

        issue("sltu", 4'd9, 32'd1, 32'hFFFFFFFF, 32'd1, 5'b00000, 1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
